rom_load_ctrl: RTL and testbench

Sequences the HPS download stream into the Pacman core and holds the core in reset until its ROM image is loaded. It sits between `hps_io` and `pacman`. It steers each ioctl byte to one of three sinks: the ROM write port (index 0), the board-variant register (index 1), or the DIP-switch bank (index 254). It owns the core reset: reset is held through boot and every ROM reload, then released after a settle interval.

---
 rtl/pacman_pkg.sv | 14 +
 rtl/rom_hold_timer.sv | 19 +
 rtl/rom_load_ctrl.sv | 96 +++++++++
 tb/tb_rom_load_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// pacman_pkg: shared state, download index and board-variant definitions for the Pacman core.
package pacman_pkg;
  typedef enum logic [1:0] {BOOT, LOAD, SETTLE, RUN} state_e;
  localparam logic [7:0] ROM_IDX = 8'd0;
  localparam logic [7:0] MOD_IDX = 8'd1;
  localparam logic [7:0] DIP_IDX = 8'd254;
  typedef enum logic [7:0] {
    ORIG, PLUS, CLUB, ORBITOR, MRTNT, WOODP, EYES, ALIBABA, CRUSH,
    BIRDIY, GORKANS, MSPAC, PONPOKO, VANVAN, SUPERABC, XENSRV, JMPST
  } variant_e;
  function automatic logic [16:0] variant_onehot(input logic [7:0] m);
    return (m <= JMPST) ? 17'd1 << m : 17'd0;
  endfunction
endpackage

// File: rtl/rom_hold_timer.sv
// rom_hold_timer: loadable down-counter that times the core-reset hold after a ROM download.
module rom_hold_timer #(
  parameter int HOLD_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);
  localparam int W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  logic [W-1:0] cnt_q;
  assign done_o = cnt_q == '0;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (load_i) cnt_q <= W'(HOLD_CYCLES - 1);
    else if (en_i && !done_o) cnt_q <= cnt_q - 1'b1;
  end
endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: steers ioctl downloads to ROM/variant/DIP sinks and holds core reset until the ROM is loaded.
module rom_load_ctrl
  import pacman_pkg::*;
#(
  parameter int         HOLD_CYCLES = 1024,
  parameter logic [7:0] ROM_INDEX   = ROM_IDX,
  parameter logic [7:0] MOD_INDEX   = MOD_IDX,
  parameter logic [7:0] DIP_INDEX   = DIP_IDX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        user_reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [7:0]  mod,
  output logic [16:0] mod_onehot,
  output logic [63:0] dip_sw,
  output logic        core_reset,
  output logic        rom_loaded,
  output logic        addr_ovf
);
  state_e            state_q, state_d;
  logic              rom_start, timer_load, timer_done;
  logic              rom_wr, addr_ok, mod_wr, dip_wr;
  logic [15:0]       dn_addr_q;
  logic [7:0]        dn_data_q, mod_q;
  logic              dn_wr_q, core_reset_q, rom_loaded_q, addr_ovf_q;
  logic [16:0]       mod_onehot_q;
  logic [7:0][7:0]   dip_q;

  rom_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (timer_load),
    .en_i   (state_q == SETTLE),
    .done_o (timer_done)
  );

  always_comb begin
    rom_start  = ioctl_download && ioctl_index == ROM_INDEX;
    timer_load = state_q == LOAD && !ioctl_download;
    state_d    = state_q == LOAD ? (ioctl_download ? LOAD : SETTLE)
               : rom_start ? LOAD
               : (state_q == SETTLE && timer_done) ? RUN
               : state_q;
    rom_wr     = ioctl_wr && ioctl_index == ROM_INDEX && state_q == LOAD;
    addr_ok    = ioctl_addr[24:16] == '0;
    mod_wr     = ioctl_wr && ioctl_index == MOD_INDEX;
    dip_wr     = ioctl_wr && ioctl_index == DIP_INDEX && ioctl_addr < 25'd8;
  end

  // core_reset is taken from the next state so it drops together with the RUN entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      core_reset_q <= 1'b1;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      mod_q        <= '0;
      mod_onehot_q <= 17'h00001;
      dip_q        <= '1;
      rom_loaded_q <= 1'b0;
      addr_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= user_reset | (state_d != RUN);
      dn_wr_q      <= rom_wr && addr_ok;
      if (rom_wr && addr_ok) begin
        dn_addr_q <= ioctl_addr[15:0];
        dn_data_q <= ioctl_dout;
      end
      if (rom_wr && !addr_ok) addr_ovf_q <= 1'b1;
      if (timer_load) rom_loaded_q <= 1'b1;
      if (mod_wr) mod_q <= ioctl_dout;
      mod_onehot_q <= variant_onehot(mod_q);
      if (dip_wr) dip_q[ioctl_addr[2:0]] <= ioctl_dout;
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign mod        = mod_q;
  assign mod_onehot = mod_onehot_q;
  assign dip_sw     = dip_q;
  assign core_reset = core_reset_q;
  assign rom_loaded = rom_loaded_q;
  assign addr_ovf   = addr_ovf_q;
endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: directed vector table plus hand sequences for rom_load_ctrl with HOLD_CYCLES=4.
module tb_rom_load_ctrl;
  localparam logic [63:0] D  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] D2 = 64'hFFFF_FFFF_FF3C_FFFF;
  logic        clk = 1'b0, reset = 1'b1, user_reset = 1'b0;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = '0, ioctl_dout = '0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data, mod;
  logic        dn_wr, core_reset, rom_loaded, addr_ovf;
  logic [16:0] mod_onehot;
  logic [63:0] dip_sw;
  int total = 0, bad = 0;

  rom_load_ctrl #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .user_reset(user_reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .mod(mod), .mod_onehot(mod_onehot), .dip_sw(dip_sw),
    .core_reset(core_reset), .rom_loaded(rom_loaded), .addr_ovf(addr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dl; logic [7:0] idx; logic wr; logic [24:0] addr; logic [7:0] dout; logic ur;
    logic e_wr; logic [15:0] e_addr; logic [7:0] e_data; logic e_cr, e_rl, e_ovf;
    logic [7:0] e_mod; logic [16:0] e_oh; logic [63:0] e_dip;
  } vec_t;
  vec_t v[$];

  task automatic row(input int dl, idx, wr, addr, dout, ur, ewr, eaddr, edata, ecr, erl, eovf, emod, eoh,
                     input logic [63:0] edip);
    vec_t r;
    r.dl = 1'(dl); r.idx = 8'(idx); r.wr = 1'(wr); r.addr = 25'(addr); r.dout = 8'(dout); r.ur = 1'(ur);
    r.e_wr = 1'(ewr); r.e_addr = 16'(eaddr); r.e_data = 8'(edata); r.e_cr = 1'(ecr); r.e_rl = 1'(erl);
    r.e_ovf = 1'(eovf); r.e_mod = 8'(emod); r.e_oh = 17'(eoh); r.e_dip = edip;
    v.push_back(r);
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(input logic dl, input logic [7:0] idx, input logic wr, input logic [24:0] addr,
                       input logic [7:0] dout, input logic ur);
    ioctl_download = dl; ioctl_index = idx; ioctl_wr = wr; ioctl_addr = addr; ioctl_dout = dout; user_reset = ur;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    //  dl idx  wr addr     dout ur | dn_wr addr     data cr rl ovf mod oh      dip
    row(1, 0,   0, 0,       0,   0,   0, 0,       0,   1, 0, 0, 0,   1,      D);
    row(1, 0,   1, 0,       'hAA,0,   1, 0,       'hAA,1, 0, 0, 0,   1,      D);
    row(1, 0,   1, 'hFFFF,  'h55,0,   1, 'hFFFF,  'h55,1, 0, 0, 0,   1,      D);
    row(1, 0,   1, 'h10000, 'h77,0,   0, 'hFFFF,  'h55,1, 0, 1, 0,   1,      D);
    row(0, 0,   1, 'h1234,  'h99,0,   1, 'h1234,  'h99,1, 1, 1, 0,   1,      D);
    for (int i = 0; i < 3; i++) row(0, 0, 0, 0, 0, 0, 0, 'h1234, 'h99, 1, 1, 1, 0, 1, D);
    row(0, 0,   0, 0,       0,   0,   0, 'h1234,  'h99,0, 1, 1, 0,   1,      D);
    row(0, 0,   0, 0,       0,   0,   0, 'h1234,  'h99,0, 1, 1, 0,   1,      D);
    row(0, 0,   0, 0,       0,   1,   0, 'h1234,  'h99,1, 1, 1, 0,   1,      D);
    row(0, 0,   0, 0,       0,   0,   0, 'h1234,  'h99,0, 1, 1, 0,   1,      D);
    row(1, 1,   1, 0,       'h05,0,   0, 'h1234,  'h99,0, 1, 1, 'h05,1,      D);
    row(1, 1,   1, 3,       'h0B,0,   0, 'h1234,  'h99,0, 1, 1, 'h0B,'h20,   D);
    row(0, 0,   0, 0,       0,   0,   0, 'h1234,  'h99,0, 1, 1, 'h0B,'h800,  D);
    row(1, 254, 1, 2,       'h3C,0,   0, 'h1234,  'h99,0, 1, 1, 'h0B,'h800,  D2);
    row(1, 254, 1, 9,       'h00,0,   0, 'h1234,  'h99,0, 1, 1, 'h0B,'h800,  D2);
    row(0, 0,   0, 0,       0,   0,   0, 'h1234,  'h99,0, 1, 1, 'h0B,'h800,  D2);
    row(1, 0,   0, 0,       0,   0,   0, 'h1234,  'h99,1, 1, 1, 'h0B,'h800,  D2);
    for (int i = 0; i < 3; i++) row(0, 0, 0, 0, 0, 0, 0, 'h1234, 'h99, 1, 1, 1, 'h0B, 'h800, D2);
    row(1, 0,   0, 0,       0,   0,   0, 'h1234,  'h99,1, 1, 1, 'h0B,'h800,  D2);
    row(1, 0,   0, 0,       0,   0,   0, 'h1234,  'h99,1, 1, 1, 'h0B,'h800,  D2);
    for (int i = 0; i < 4; i++) row(0, 0, 0, 0, 0, 0, 0, 'h1234, 'h99, 1, 1, 1, 'h0B, 'h800, D2);
    row(0, 0,   0, 0,       0,   0,   0, 'h1234,  'h99,0, 1, 1, 'h0B,'h800,  D2);

    tick; tick;
    chk("rst core_reset", core_reset, 1); chk("rst dn_wr", dn_wr, 0); chk("rst dn_addr", dn_addr, 0);
    chk("rst dn_data", dn_data, 0); chk("rst mod", mod, 0); chk("rst mod_onehot", mod_onehot, 1);
    chk("rst dip_sw", dip_sw, D); chk("rst rom_loaded", rom_loaded, 0); chk("rst addr_ovf", addr_ovf, 0);
    reset = 1'b0;
    tick;
    chk("boot core_reset", core_reset, 1);

    foreach (v[i]) begin
      drive(v[i].dl, v[i].idx, v[i].wr, v[i].addr, v[i].dout, v[i].ur);
      tick;
      chk($sformatf("r%0d dn_wr", i), dn_wr, v[i].e_wr);
      chk($sformatf("r%0d dn_addr", i), dn_addr, v[i].e_addr);
      chk($sformatf("r%0d dn_data", i), dn_data, v[i].e_data);
      chk($sformatf("r%0d core_reset", i), core_reset, v[i].e_cr);
      chk($sformatf("r%0d rom_loaded", i), rom_loaded, v[i].e_rl);
      chk($sformatf("r%0d addr_ovf", i), addr_ovf, v[i].e_ovf);
      chk($sformatf("r%0d mod", i), mod, v[i].e_mod);
      chk($sformatf("r%0d mod_onehot", i), mod_onehot, v[i].e_oh);
      chk($sformatf("r%0d dip_sw", i), dip_sw, v[i].e_dip);
    end

    // variant codes at and beyond the last named board
    drive(1, 8'd1, 1, 25'd0, 8'h10, 0); tick;
    chk("mod 0x10", mod, 8'h10);
    drive(1, 8'd1, 1, 25'd0, 8'h11, 0); tick;
    chk("onehot 0x10", mod_onehot, 17'h10000);
    drive(0, 8'd0, 0, 25'd0, 8'h00, 0); tick;
    chk("onehot 0x11", mod_onehot, 17'h00000);
    chk("variant core_reset", core_reset, 0);

    // reset in the middle of a ROM download
    drive(1, 8'd0, 0, 25'd0, 8'h00, 0); tick;
    chk("reload core_reset", core_reset, 1);
    reset = 1'b1; tick;
    chk("midload rom_loaded", rom_loaded, 0); chk("midload mod", mod, 0);
    chk("midload dip_sw", dip_sw, D); chk("midload addr_ovf", addr_ovf, 0);
    chk("midload mod_onehot", mod_onehot, 1); chk("midload dn_addr", dn_addr, 0);
    reset = 1'b0;
    drive(0, 8'd0, 0, 25'd0, 8'h00, 0);
    repeat (8) tick;
    chk("post-reset boot core_reset", core_reset, 1);
    chk("post-reset rom_loaded", rom_loaded, 0);

    // fresh download after reset: release must take HOLD_CYCLES+1 cycles from the drop
    drive(1, 8'd0, 0, 25'd0, 8'h00, 0); tick;
    drive(0, 8'd0, 0, 25'd0, 8'h00, 0);
    n = 0;
    while (core_reset !== 1'b0 && n < 50) begin
      tick;
      n++;
    end
    chk("restart release latency", 64'(n), 5);
    chk("restart rom_loaded", rom_loaded, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
